// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int DATA_BITS            = 8;
   localparam int CLKS_PER_BIT_DEFAULT = 10417;   // 100 MHz / 9600 baud
   localparam int FRAME_BITS           = 10;      // start + 8 data + stop

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte buffer that queues bytes for the UART transmitter.
// Latency: a pushed byte is visible on dout/empty one cycle after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty; push and pop may share an edge.
//
// Ports: clk, reset (async active-low), push/din (write side), pop/dout (read side),
//        full (count == FIFO_DEPTH), empty (count == 0).
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_BITS-1:0] din,
   output logic [DATA_BITS-1:0] dout,
   output logic                 full,
   output logic                 empty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W:0]       count;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers are exactly log2(depth) wide, so they wrap without compare logic.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; entries are only read behind a valid count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte queue; frames are sent back-to-back.
// Latency: byte written at edge N into an empty queue drives the start bit from edge N+1.
// Backpressure: tx_full while the queue is full; writes while full are dropped and set sticky tx_overflow.
//
// Ports: clk, reset (async active-low), tx_data/tx_wr (byte write), tx_full, tx_busy,
//        tx_overflow (sticky until reset), TX (registered serial line, idles high).
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int FIFO_DEPTH   = 4
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_wr,
   output logic                 tx_full,
   output logic                 tx_busy,
   output logic                 tx_overflow,
   output logic                 TX
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

   tx_state_t            state;
   logic [CNT_W-1:0]     baud_cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 fifo_empty;
   logic                 bit_end;
   logic                 pop;

   assign bit_end = (baud_cnt == BAUD_LAST);
   assign tx_busy = !fifo_empty || (state != IDLE);

   // Head is taken either from idle or at the last cycle of a stop bit, which
   // is what lets queued frames follow each other without an idle cycle.
   always_comb begin
      pop = 1'b0;
      if (!fifo_empty) begin
         if (state == IDLE)
            pop = 1'b1;
         else if (state == STOP && bit_end)
            pop = 1'b1;
      end
   end

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_wr),
      .pop   (pop),
      .din   (tx_data),
      .dout  (fifo_dout),
      .full  (tx_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         tx_overflow <= 1'b0;
      else if (tx_wr && tx_full)
         tx_overflow <= 1'b1;
   end

   // TX is registered and loaded with the value of the bit that starts at
   // this edge, so the line only ever changes on bit boundaries.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         TX       <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shift    <= fifo_dout;
                  baud_cnt <= '0;
                  state    <= START;
                  TX       <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  TX       <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == BIT_LAST) begin
                     state <= STOP;
                     TX    <= 1'b1;
                  end else begin
                     // shift[1] is the bit that becomes shift[0] after this edge.
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + 1'b1;
                     TX      <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift <= fifo_dout;
                     state <= START;
                     TX    <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               baud_cnt <= '0;
               TX       <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 16 clocks per bit, depth-4 queue.
// Reference: queue of accepted bytes plus a frame clock; line value derived from frame position.
// A separate line decoder recovers bytes from TX and matches them against frames the model started.
module tb_uart_tx;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       tx_full;
   logic       tx_busy;
   logic       tx_overflow;
   logic       TX;

   always #5 clk = ~clk;

   uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tx_data     (tx_data),
      .tx_wr       (tx_wr),
      .tx_full     (tx_full),
      .tx_busy     (tx_busy),
      .tx_overflow (tx_overflow),
      .TX          (TX)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_q[$];      // accepted, not yet started
   logic [7:0] sent_q[$];   // frames started, awaiting decode
   bit         m_active;
   int         m_t;         // cycle index inside the current frame
   logic [7:0] m_byte;
   bit         m_ovf;

   function automatic logic m_line();
      int k;
      if (!m_active) return 1'b1;
      k = m_t / CPB;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_byte[k-1];
   endfunction

   task automatic model_edge(input bit wr, input logic [7:0] d);
      bit had_data;
      bit was_full;
      had_data = (m_q.size() != 0);
      was_full = (m_q.size() == DEPTH);
      if (m_active) begin
         if (m_t == FRAME - 1) m_active = 0;
         else m_t++;
      end
      if (!m_active && had_data) begin
         m_byte = m_q.pop_front();
         sent_q.push_back(m_byte);
         m_active = 1;
         m_t = 0;
      end
      if (wr) begin
         if (was_full) m_ovf = 1;
         else m_q.push_back(d);
      end
   endtask

   // ---------------- line decoder ----------------
   bit         rx_on;
   int         rx_t;
   logic [7:0] rx_b;
   int         rx_count = 0;

   task automatic model_reset();
      m_q.delete();
      sent_q.delete();
      m_active = 0;
      m_t = 0;
      m_ovf = 0;
      rx_on = 0;
      rx_t = 0;
   endtask

   task automatic rx_sample();
      int k;
      logic [8:0] want;
      if (!rx_on && TX === 1'b0) begin
         rx_on = 1;
         rx_t = 0;
      end
      if (rx_on) begin
         if (rx_t % CPB == CPB / 2) begin
            k = rx_t / CPB;
            if (k == 0) check("rx_start_bit", TX, 0);
            else if (k <= 8) rx_b[k-1] = TX;
            else begin
               check("rx_stop_bit", TX, 1);
               rx_on = 0;
               want = (sent_q.size() != 0) ? {1'b0, sent_q.pop_front()} : 9'h100;
               check("rx_byte", rx_b, want);
               rx_count++;
            end
         end
         if (rx_on) rx_t++;
      end
   endtask

   task automatic check_outputs();
      check("tx_line", TX, m_line());
      check("tx_busy", tx_busy, m_active || (m_q.size() != 0));
      check("tx_full", tx_full, m_q.size() == DEPTH);
      check("tx_overflow", tx_overflow, m_ovf);
   endtask

   // One clock: drive inputs at the negedge, apply the edge, check at next negedge.
   task automatic step(input bit wr, input logic [7:0] d);
      tx_wr = wr;
      tx_data = d;
      @(posedge clk);
      model_edge(wr, d);
      @(negedge clk);
      tx_wr = 1'b0;
      check_outputs();
      rx_sample();
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && (tx_busy === 1'b1 || rx_on); i++)
         step(1'b0, 8'h00);
      check("drain_idle", tx_busy, 0);
   endtask

   int first_low;
   int first_idle;
   int rx_base;
   logic [7:0] burst [6];

   initial begin
      reset = 1'b0;
      tx_wr = 1'b0;
      tx_data = 8'h00;
      model_reset();

      // Reset state and quiet line
      repeat (5) @(negedge clk);
      check("rst_tx", TX, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_full", tx_full, 0);
      check("rst_ovf", tx_overflow, 0);
      reset = 1'b1;
      repeat (200) step(1'b0, 8'h00);

      // Single byte 0x55: start at edge 1, idle from edge 161
      first_low = -1;
      first_idle = -1;
      step(1'b1, 8'h55);
      for (int i = 1; i <= 200; i++) begin
         step(1'b0, 8'h00);
         if (first_low < 0 && TX === 1'b0) first_low = i;
         if (first_idle < 0 && tx_busy === 1'b0) first_idle = i;
      end
      check("single_start_edge", first_low, 1);
      check("single_idle_edge", first_idle, 161);

      // Burst of six: fifth write fills, sixth is dropped, five frames back-to-back
      burst = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h81, 8'h7E};
      rx_base = rx_count;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, burst[i]);
         if (i == 4) check("burst_full_after5", tx_full, 1);
      end
      check("burst_overflow", tx_overflow, 1);
      first_idle = -1;
      for (int i = 6; i <= 900; i++) begin
         step(1'b0, 8'h00);
         if (first_idle < 0 && tx_busy === 1'b0) first_idle = i;
      end
      check("burst_idle_edge", first_idle, 801);
      check("burst_frames", rx_count - rx_base, 5);

      // Push on the stop-end edge while three entries are queued
      rx_base = rx_count;
      step(1'b1, 8'h11);
      step(1'b1, 8'h22);
      step(1'b1, 8'h33);
      step(1'b1, 8'h44);
      repeat (157) step(1'b0, 8'h00);
      step(1'b1, 8'h55);
      check("pp_restart", TX, 0);
      check("pp_not_full", tx_full, 0);
      drain();
      check("pp_frames", rx_count - rx_base, 5);

      // Asynchronous reset during data bit 3 of 0xC3 (bit 3 is 0)
      step(1'b1, 8'hC3);
      repeat (69) step(1'b0, 8'h00);
      check("mid_bit3_low", TX, 0);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check("mid_async_tx", TX, 1);
      check("mid_async_busy", tx_busy, 0);
      check("mid_async_ovf", tx_overflow, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      rx_base = rx_count;
      repeat (300) step(1'b0, 8'h00);
      check("mid_no_frames", rx_count - rx_base, 0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++)
         step($urandom_range(0, 99) < 2, 8'($urandom));
      for (int i = 0; i < 8; i++)
         step(1'b1, 8'($urandom));
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 99) < 1, 8'($urandom));
      drain();
      check("all_frames_decoded", sent_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the CPU's UART peripheral. It is the transmit counterpart of the existing RX path and drives the top-level TX pin.
- Frame format: 8N1 (1 start bit, 8 data bits LSB first, no parity, 1 stop bit). Default rate is 9600 baud from the 100 MHz system clock.
- Bytes written by the CPU bus logic are buffered in a small FIFO and sent back-to-back. There is no idle gap between queued frames.

Parameters:
- CLKS_PER_BIT, 10417: clock cycles per bit (100 MHz / 9600). Legal range is 2 or more. The baud counter width is ceil(log2(CLKS_PER_BIT)).
- FIFO_DEPTH, 4: transmit buffer entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to queue.
- tx_wr  in  1  write strobe, sampled on the rising clk edge.
- tx_full  out  1  FIFO holds FIFO_DEPTH entries.
- tx_busy  out  1  high while the FIFO is non-empty or a frame is on the line.
- tx_overflow  out  1  sticky flag: a write was dropped while the FIFO was full.
- TX  out  1  serial line. Idles high. Registered output.

Behaviour:
- Reset (reset==0, takes effect immediately and without waiting for clk):
  - TX=1, tx_busy=0, tx_full=0, tx_overflow=0.
  - FIFO is emptied and pointers are 0.
  - FSM goes to IDLE; baud counter and bit index are 0.
- Reset mid-frame: the frame is abandoned and TX returns to 1 asynchronously. Queued bytes are lost.
- Push:
  - If tx_wr=1 and tx_full=0 at an edge, tx_data is written to the FIFO tail.
  - If tx_wr=1 while tx_full=1, the byte is dropped, FIFO state is unchanged, and tx_overflow is set to 1. It stays 1 until reset.
- tx_full and tx_busy are combinational from registered state. tx_full means count==FIFO_DEPTH.
- Simultaneous push and pop in the same cycle is legal. Count is unchanged and both operations complete.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - TX=1.
    - If the FIFO is non-empty at an edge: pop the head into the shift register, clear the baud counter, go to START, and drive TX=0 from that edge.
    - Latency: a tx_wr accepted at edge N into an empty FIFO gives TX falling after edge N+1.
  - START:
    - TX=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - TX=shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the bit index.
    - After bit index 7 completes, go to STOP.
  - STOP:
    - TX=1 for CLKS_PER_BIT cycles.
    - At the end, if the FIFO is non-empty, pop and go directly to START in the same edge (no idle cycle). Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Every TX transition occurs only on a bit boundary.
- The baud counter runs only outside IDLE. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- tx_busy falls on the same edge the FSM enters IDLE with an empty FIFO.
- The FIFO uses a circular buffer. Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE/START/DATA/STOP).
  - DATA_BITS=8.
  - Default CLKS_PER_BIT=10417.
  - Frame bit count of 10.
- Sub-module uart_tx_fifo (parameter FIFO_DEPTH, 8-bit width):
  - Ports: push, pop, din, dout, full, empty.
  - Same clk and reset as uart_tx.
- uart_tx instantiates uart_tx_fifo and holds the FSM, baud counter, shift register and overflow flag.

Test Plan (bench uses CLKS_PER_BIT=16 unless noted):
- Reset: hold reset=0 for 5 cycles -> TX=1, tx_busy=0, tx_full=0, tx_overflow=0. Release with no writes -> TX remains 1 for 200 cycles.
- Single byte: tx_wr with 0x55 at edge 0 -> TX=0 over cycles 1..16. Then data bits 1,0,1,0,1,0,1,0, 16 cycles each. Then stop bit =1 for 16 cycles. tx_busy=0 from edge 161.
- Burst and overflow: write 0x00,0xFF,0xA5,0x3C,0x81,0x7E on 6 consecutive edges.
  - tx_full=1 after the 5th write; 0x7E is dropped and tx_overflow=1.
  - Five contiguous frames follow: 800 cycles with no idle gap, decoded as 00,FF,A5,3C,81.
- Simultaneous push/pop: keep the FIFO at 3 entries and write on the STOP-end edge of a frame -> count stays 3 and no byte is lost or duplicated.
- Reset mid-frame: drive reset=0 during data bit 3 of 0xC3 -> TX=1 immediately (no clk edge needed). After release: tx_busy=0, no further frames, FIFO empty.
- Default rate loopback: CLKS_PER_BIT=10417, TX wired to the CPU's UART receiver, send 0x5A -> receiver reports 0x5A. Bit period measures 104170 ns ±10 ns.
